// File: rtl/hazard_pkg.sv
// Shared types, constants and the register-match helper for the hazard controller.
package hazard_pkg;

    localparam int unsigned REG_W_DEF  = 4;
    localparam int unsigned ADDR_MAX_W = 8;

    typedef enum logic [1:0] {
        RUN       = 2'b00,
        LOAD_WAIT = 2'b01,
        FLUSH     = 2'b10
    } state_t;

    typedef logic [1:0] fwd_sel_t;

    localparam fwd_sel_t FWD_RF  = 2'b00;
    localparam fwd_sel_t FWD_WB  = 2'b01;
    localparam fwd_sel_t FWD_MEM = 2'b10;

    // Register reference widened to a common address width so any REG_W fits.
    typedef struct packed {
        logic [ADDR_MAX_W-1:0] addr;
        logic                  vf;
    } reg_ref_t;

    // Scalar r0 is hard-wired zero and never matches; vector v0 is a real register.
    function automatic logic reg_match(input reg_ref_t src, input reg_ref_t dst,
                                       input logic dst_we);
        return dst_we && (src == dst) && (src.vf || (src.addr != '0));
    endfunction

endpackage

// File: rtl/hazard_control_unit_if.sv
// Pipeline-side view of the hazard controller: stage tags in, selects and enables out.
interface hazard_control_unit_if
    import hazard_pkg::*;
#(
    parameter int unsigned REG_W = REG_W_DEF
) ();

    logic [REG_W-1:0] RS1_D;
    logic [REG_W-1:0] RS2_D;
    logic             Use1_D;
    logic             Use2_D;
    logic             VF_D;

    logic [REG_W-1:0] RS1_E;
    logic [REG_W-1:0] RS2_E;
    logic             VF_E;
    logic [REG_W-1:0] RD_E;
    logic             VFD_E;
    logic             RegW_E;
    logic             MemRd_E;

    logic [REG_W-1:0] RD_M;
    logic             VF_M;
    logic             RegW_M;

    logic [REG_W-1:0] RD_W;
    logic             VF_W;
    logic             RegW_W;

    logic             JmpSel_E;
    logic             mem_ready;

    fwd_sel_t         FwdA_E;
    fwd_sel_t         FwdB_E;
    logic             Stall_F;
    logic             Stall_D;
    logic             Flush_D;
    logic             Flush_E;
    logic             err;
    logic [1:0]       state_o;

    modport master (
        output RS1_D, RS2_D, Use1_D, Use2_D, VF_D,
        output RS1_E, RS2_E, VF_E, RD_E, VFD_E, RegW_E, MemRd_E,
        output RD_M, VF_M, RegW_M, RD_W, VF_W, RegW_W,
        output JmpSel_E, mem_ready,
        input  FwdA_E, FwdB_E, Stall_F, Stall_D, Flush_D, Flush_E, err, state_o
    );

    modport slave (
        input  RS1_D, RS2_D, Use1_D, Use2_D, VF_D,
        input  RS1_E, RS2_E, VF_E, RD_E, VFD_E, RegW_E, MemRd_E,
        input  RD_M, VF_M, RegW_M, RD_W, VF_W, RegW_W,
        input  JmpSel_E, mem_ready,
        output FwdA_E, FwdB_E, Stall_F, Stall_D, Flush_D, Flush_E, err, state_o
    );

endinterface

// File: rtl/forward_unit.sv
// Combinational operand-forwarding select: MEM result beats WB result beats register file.
module forward_unit
    import hazard_pkg::*;
(
    input  reg_ref_t src_a,
    input  reg_ref_t src_b,
    input  reg_ref_t dst_m,
    input  logic     we_m,
    input  reg_ref_t dst_w,
    input  logic     we_w,
    output fwd_sel_t fwd_a_c,
    output fwd_sel_t fwd_b_c
);

    always_comb begin
        fwd_a_c = FWD_RF;
        fwd_b_c = FWD_RF;

        if (reg_match(src_a, dst_m, we_m)) begin
            fwd_a_c = FWD_MEM;
        end else if (reg_match(src_a, dst_w, we_w)) begin
            fwd_a_c = FWD_WB;
        end

        if (reg_match(src_b, dst_m, we_m)) begin
            fwd_b_c = FWD_MEM;
        end else if (reg_match(src_b, dst_w, we_w)) begin
            fwd_b_c = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_control_unit.sv
// Hazard controller: forwarding selects, load-use stall sequencing and jump flush sequencing.
module hazard_control_unit
    import hazard_pkg::*;
#(
    parameter int unsigned REG_W     = REG_W_DEF,
    parameter int unsigned FLUSH_CYC = 2,
    parameter int unsigned LOAD_TO   = 15
) (
    input logic                  clk,
    input logic                  rst,
    hazard_control_unit_if.slave hif
);

    localparam int unsigned WCNT_W = (LOAD_TO > 0) ? $clog2(LOAD_TO + 1) : 1;
    localparam int unsigned FCNT_W = (FLUSH_CYC > 0) ? $clog2(FLUSH_CYC + 1) : 1;

    function automatic reg_ref_t to_ref(input logic [REG_W-1:0] a, input logic vf);
        return '{addr: ADDR_MAX_W'(a), vf: vf};
    endfunction

    state_t             state_q, state_d;
    logic [WCNT_W-1:0]  wcnt_q, wcnt_d;
    logic [FCNT_W-1:0]  fcnt_q, fcnt_d;
    logic               err_q, err_d;

    reg_ref_t src1_d, src2_d, dst_e;
    reg_ref_t src1_e, src2_e, dst_m, dst_w;
    fwd_sel_t fwd_a_c, fwd_b_c;
    logic     load_use_c;

    logic     stall_c, flush_d_c, flush_e_c;
    fwd_sel_t fwd_a_out_c, fwd_b_out_c;

    assign src1_d = to_ref(hif.RS1_D, hif.VF_D);
    assign src2_d = to_ref(hif.RS2_D, hif.VF_D);
    assign dst_e  = to_ref(hif.RD_E, hif.VFD_E);
    assign src1_e = to_ref(hif.RS1_E, hif.VF_E);
    assign src2_e = to_ref(hif.RS2_E, hif.VF_E);
    assign dst_m  = to_ref(hif.RD_M, hif.VF_M);
    assign dst_w  = to_ref(hif.RD_W, hif.VF_W);

    forward_unit u_fwd (
        .src_a   (src1_e),
        .src_b   (src2_e),
        .dst_m   (dst_m),
        .we_m    (hif.RegW_M),
        .dst_w   (dst_w),
        .we_w    (hif.RegW_W),
        .fwd_a_c (fwd_a_c),
        .fwd_b_c (fwd_b_c)
    );

    // A load in EX whose destination feeds a live decode source needs one or more bubbles.
    assign load_use_c = hif.MemRd_E &&
                        ((hif.Use1_D && reg_match(src1_d, dst_e, hif.RegW_E)) ||
                         (hif.Use2_D && reg_match(src2_d, dst_e, hif.RegW_E)));

    // State and counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
            wcnt_q  <= '0;
            fcnt_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            fcnt_q  <= fcnt_d;
            err_q   <= err_d;
        end
    end

    // Next-state and counter update.
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        fcnt_d  = fcnt_q;
        err_d   = err_q;

        unique case (state_q)
            RUN: begin
                if (hif.JmpSel_E) begin
                    if (FLUSH_CYC > 0) begin
                        state_d = FLUSH;
                        fcnt_d  = FCNT_W'(FLUSH_CYC - 1);
                    end
                end else if (load_use_c && !hif.mem_ready) begin
                    state_d = LOAD_WAIT;
                    wcnt_d  = '0;
                end
            end
            LOAD_WAIT: begin
                if (hif.mem_ready) begin
                    state_d = RUN;
                end else if (wcnt_q == WCNT_W'(LOAD_TO)) begin
                    err_d   = 1'b1;
                    state_d = RUN;
                end else begin
                    wcnt_d = wcnt_q + WCNT_W'(1);
                end
            end
            FLUSH: begin
                if (fcnt_q == '0) begin
                    state_d = RUN;
                end else begin
                    fcnt_d = fcnt_q - FCNT_W'(1);
                end
            end
            default: state_d = RUN;
        endcase
    end

    // Control outputs; everything is held quiet while reset is asserted.
    always_comb begin
        stall_c     = 1'b0;
        flush_d_c   = 1'b0;
        flush_e_c   = 1'b0;
        fwd_a_out_c = FWD_RF;
        fwd_b_out_c = FWD_RF;

        if (rst) begin
            fwd_a_out_c = fwd_a_c;
            fwd_b_out_c = fwd_b_c;
            unique case (state_q)
                RUN: begin
                    if (hif.JmpSel_E) begin
                        flush_d_c = 1'b1;
                        flush_e_c = 1'b1;
                    end else if (load_use_c) begin
                        stall_c   = 1'b1;
                        flush_e_c = 1'b1;
                    end
                end
                LOAD_WAIT: begin
                    stall_c   = 1'b1;
                    flush_e_c = 1'b1;
                end
                FLUSH: flush_d_c = 1'b1;
                default: ;
            endcase
        end
    end

    assign hif.FwdA_E  = fwd_a_out_c;
    assign hif.FwdB_E  = fwd_b_out_c;
    assign hif.Stall_F = stall_c;
    assign hif.Stall_D = stall_c;
    assign hif.Flush_D = flush_d_c;
    assign hif.Flush_E = flush_e_c;
    assign hif.err     = err_q;
    assign hif.state_o = state_q;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Self-checking bench: forwarding/load-use vector table plus stall, timeout, flush and reset sequences.
module tb_hazard_control_unit;

    typedef struct packed {
        logic [3:0] RS1_D, RS2_D;
        logic       Use1_D, Use2_D, VF_D;
        logic [3:0] RS1_E, RS2_E;
        logic       VF_E;
        logic [3:0] RD_E;
        logic       VFD_E, RegW_E, MemRd_E;
        logic [3:0] RD_M;
        logic       VF_M, RegW_M;
        logic [3:0] RD_W;
        logic       VF_W, RegW_W;
        logic       JmpSel_E, mem_ready;
    } in_t;

    typedef struct packed {
        logic [1:0] fa, fb;
        logic       sf, sd, fd, fe, err;
        logic [1:0] st;
    } exp_t;

    typedef struct packed {
        in_t  in;
        exp_t ex;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;
    exp_t exp_q[$];
    vec_t tbl[$];

    always #5 clk = ~clk;

    hazard_control_unit_if #(.REG_W(4)) hif ();

    hazard_control_unit #(.REG_W(4), .FLUSH_CYC(2), .LOAD_TO(15)) dut (
        .clk (clk),
        .rst (rst),
        .hif (hif)
    );

    task automatic drive(input in_t iv);
        hif.RS1_D = iv.RS1_D;   hif.RS2_D = iv.RS2_D;
        hif.Use1_D = iv.Use1_D; hif.Use2_D = iv.Use2_D; hif.VF_D = iv.VF_D;
        hif.RS1_E = iv.RS1_E;   hif.RS2_E = iv.RS2_E;   hif.VF_E = iv.VF_E;
        hif.RD_E = iv.RD_E;     hif.VFD_E = iv.VFD_E;
        hif.RegW_E = iv.RegW_E; hif.MemRd_E = iv.MemRd_E;
        hif.RD_M = iv.RD_M;     hif.VF_M = iv.VF_M;     hif.RegW_M = iv.RegW_M;
        hif.RD_W = iv.RD_W;     hif.VF_W = iv.VF_W;     hif.RegW_W = iv.RegW_W;
        hif.JmpSel_E = iv.JmpSel_E;
        hif.mem_ready = iv.mem_ready;
    endtask

    function automatic exp_t snap();
        exp_t a;
        a.fa = hif.FwdA_E;   a.fb = hif.FwdB_E;
        a.sf = hif.Stall_F;  a.sd = hif.Stall_D;
        a.fd = hif.Flush_D;  a.fe = hif.Flush_E;
        a.err = hif.err;     a.st = hif.state_o;
        return a;
    endfunction

    function automatic exp_t ex(input logic stall, input logic fd, input logic fe,
                                input logic err, input logic [1:0] st);
        exp_t e;
        e.fa = 2'b00; e.fb = 2'b00;
        e.sf = stall; e.sd = stall;
        e.fd = fd;    e.fe = fe;
        e.err = err;  e.st = st;
        return e;
    endfunction

    function automatic in_t load_use(input logic mr);
        in_t iv = '0;
        iv.MemRd_E = 1'b1; iv.RegW_E = 1'b1; iv.RD_E = 4'd5;
        iv.RS2_D = 4'd5;   iv.Use2_D = 1'b1; iv.mem_ready = mr;
        return iv;
    endfunction

    task automatic check_pop(input string nm);
        exp_t a, e;
        a = snap();
        tests++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL %s: scoreboard empty", nm);
        end else begin
            e = exp_q.pop_front();
            if (a !== e) begin
                fails++;
                $display("FAIL %s: got fa=%b fb=%b sf=%b sd=%b fd=%b fe=%b err=%b st=%b, expected fa=%b fb=%b sf=%b sd=%b fd=%b fe=%b err=%b st=%b",
                         nm, a.fa, a.fb, a.sf, a.sd, a.fd, a.fe, a.err, a.st,
                         e.fa, e.fb, e.sf, e.sd, e.fd, e.fe, e.err, e.st);
            end
        end
    endtask

    // One clock: drive, queue the expectation, sample at negedge, advance past the posedge.
    task automatic step(input in_t iv, input exp_t e, input string nm);
        drive(iv);
        exp_q.push_back(e);
        @(negedge clk);
        check_pop(nm);
        @(posedge clk);
        #1;
    endtask

    task automatic add(input in_t iv, input logic [1:0] fa, input logic [1:0] fb,
                       input logic lu);
        vec_t v;
        v.in = iv;
        v.ex = ex(lu, 1'b0, lu, 1'b0, 2'b00);
        v.ex.fa = fa;
        v.ex.fb = fb;
        tbl.push_back(v);
    endtask

    initial begin
        in_t iv;

        // Forwarding vectors (all in RUN, no load in EX).
        iv = '0; iv.RS1_E = 4'd2; iv.RD_M = 4'd2; iv.RegW_M = 1'b1;
        add(iv, 2'b10, 2'b00, 1'b0);
        iv.RD_W = 4'd2; iv.RegW_W = 1'b1;
        add(iv, 2'b10, 2'b00, 1'b0);
        iv.RegW_M = 1'b0;
        add(iv, 2'b01, 2'b00, 1'b0);
        iv = '0; iv.RS1_E = 4'd2; iv.RD_M = 4'd2; iv.RegW_M = 1'b1; iv.VF_M = 1'b1;
        add(iv, 2'b00, 2'b00, 1'b0);
        iv = '0; iv.RD_M = 4'd0; iv.RegW_M = 1'b1; iv.RD_W = 4'd0; iv.RegW_W = 1'b1;
        add(iv, 2'b00, 2'b00, 1'b0);
        iv = '0; iv.VF_E = 1'b1; iv.RS2_E = 4'd3; iv.VF_M = 1'b1; iv.RegW_M = 1'b1;
        add(iv, 2'b10, 2'b00, 1'b0);
        iv = '0; iv.RS1_E = 4'd7; iv.RS2_E = 4'd7; iv.RD_W = 4'd7; iv.RegW_W = 1'b1;
        add(iv, 2'b01, 2'b01, 1'b0);
        iv = '0; iv.RS1_E = 4'd4; iv.RS2_E = 4'd9; iv.RD_M = 4'd9; iv.RegW_M = 1'b1;
        iv.RD_W = 4'd4; iv.RegW_W = 1'b1;
        add(iv, 2'b01, 2'b10, 1'b0);
        iv = '0; iv.VF_E = 1'b1; iv.RS1_E = 4'd5; iv.RD_W = 4'd5; iv.RegW_W = 1'b1;
        add(iv, 2'b00, 2'b00, 1'b0);
        // Load-use with data ready the same cycle: single bubble, stays in RUN.
        add(load_use(1'b1), 2'b00, 2'b00, 1'b1);
        iv = load_use(1'b1); iv.Use2_D = 1'b0;
        add(iv, 2'b00, 2'b00, 1'b0);
        iv = '0; iv.MemRd_E = 1'b1; iv.RegW_E = 1'b1; iv.RD_E = 4'd3;
        iv.RS1_D = 4'd3; iv.Use1_D = 1'b1; iv.VF_D = 1'b1; iv.mem_ready = 1'b1;
        add(iv, 2'b00, 2'b00, 1'b0);
        iv.VFD_E = 1'b1;
        add(iv, 2'b00, 2'b00, 1'b1);
        iv = '0; iv.MemRd_E = 1'b1; iv.RegW_E = 1'b1; iv.Use1_D = 1'b1; iv.mem_ready = 1'b1;
        add(iv, 2'b00, 2'b00, 1'b0);
        iv.VF_D = 1'b1; iv.VFD_E = 1'b1;
        add(iv, 2'b00, 2'b00, 1'b1);
        iv = load_use(1'b1); iv.MemRd_E = 1'b0;
        add(iv, 2'b00, 2'b00, 1'b0);

        // Reset held with random inputs.
        rst = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            iv = in_t'({$urandom(), $urandom()});
            step(iv, ex(1'b0, 1'b0, 1'b0, 1'b0, 2'b00), "reset_hold");
        end
        rst = 1'b1;
        step('0, ex(1'b0, 1'b0, 1'b0, 1'b0, 2'b00), "idle0");
        step('0, ex(1'b0, 1'b0, 1'b0, 1'b0, 2'b00), "idle1");

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].in, tbl[i].ex, $sformatf("vec%0d", i));
        end

        // Load-use with data arriving three cycles late.
        step(load_use(1'b0), ex(1'b1, 1'b0, 1'b1, 1'b0, 2'b00), "lu_run");
        step(load_use(1'b0), ex(1'b1, 1'b0, 1'b1, 1'b0, 2'b01), "lu_w1");
        step(load_use(1'b0), ex(1'b1, 1'b0, 1'b1, 1'b0, 2'b01), "lu_w2");
        step(load_use(1'b1), ex(1'b1, 1'b0, 1'b1, 1'b0, 2'b01), "lu_w3");
        step('0, ex(1'b0, 1'b0, 1'b0, 1'b0, 2'b00), "lu_done");

        // Load timeout: 1 RUN cycle plus 16 LOAD_WAIT cycles of stall.
        step(load_use(1'b0), ex(1'b1, 1'b0, 1'b1, 1'b0, 2'b00), "to_run");
        for (int i = 0; i < 16; i++) begin
            step(load_use(1'b0), ex(1'b1, 1'b0, 1'b1, 1'b0, 2'b01), $sformatf("to_wait%0d", i));
        end
        step('0, ex(1'b0, 1'b0, 1'b0, 1'b1, 2'b00), "to_end");
        step('0, ex(1'b0, 1'b0, 1'b0, 1'b1, 2'b00), "to_sticky");

        // Taken jump with a simultaneous load-use: flush wins, no stall.
        iv = load_use(1'b0); iv.JmpSel_E = 1'b1;
        step(iv, ex(1'b0, 1'b1, 1'b1, 1'b1, 2'b00), "jmp");
        step(load_use(1'b0), ex(1'b0, 1'b1, 1'b0, 1'b1, 2'b10), "jmp_fl1");
        step(load_use(1'b0), ex(1'b0, 1'b1, 1'b0, 1'b1, 2'b10), "jmp_fl2");
        step('0, ex(1'b0, 1'b0, 1'b0, 1'b1, 2'b00), "jmp_done");

        // Asynchronous reset in the middle of LOAD_WAIT.
        step(load_use(1'b0), ex(1'b1, 1'b0, 1'b1, 1'b1, 2'b00), "ar_run");
        step(load_use(1'b0), ex(1'b1, 1'b0, 1'b1, 1'b1, 2'b01), "ar_wait");
        #2;
        rst = 1'b0;
        #1;
        exp_q.push_back(ex(1'b0, 1'b0, 1'b0, 1'b0, 2'b00));
        check_pop("ar_async");
        @(posedge clk);
        #1;
        rst = 1'b1;
        step('0, ex(1'b0, 1'b0, 1'b0, 1'b0, 2'b00), "ar_after");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/hazard_control_unit.md
Name: hazard_control_unit

Overview:
- Pipeline hazard controller for the vector ASIP execute datapath.
- Generates operand-forwarding selects for the execute stage, which choose between the register-file value, the MEM-stage ALU result and the WB-stage result.
- Sequences stalls for load-use hazards and flushes for taken jumps.
- Sits beside execute_module; its outputs drive the IF/ID and ID/EX pipeline-register enables and clears, and the execute operand muxes.

Parameters:
- REG_W, 4, register address width (scalar and vector files share the encoding).
- FLUSH_CYC, 2, cycles Flush_D stays asserted after a taken jump (covers instruction-memory latency).
- LOAD_TO, 15, maximum LOAD_WAIT cycles before the error flag sets.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- RS1_D, RS2_D  in  REG_W  decode-stage source addresses.
- Use1_D, Use2_D  in  1  decode instruction reads RS1/RS2.
- VF_D  in  1  decode sources are vector registers.
- RS1_E, RS2_E  in  REG_W  execute-stage source addresses.
- VF_E  in  1  execute sources are vector registers.
- RD_E  in  REG_W  execute destination.
- VFD_E, RegW_E, MemRd_E  in  1  execute destination is vector / writes / is a load.
- RD_M  in  REG_W  MEM-stage destination.
- VF_M, RegW_M  in  1  MEM destination flags.
- RD_W  in  REG_W  WB-stage destination.
- VF_W, RegW_W  in  1  WB destination flags.
- JmpSel_E  in  1  taken jump resolved in execute.
- mem_ready  in  1  data memory returns load data this cycle.
- FwdA_E, FwdB_E  out  2  operand select: 00 register file, 01 WB result, 10 MEM ALU result.
- Stall_F, Stall_D  out  1  hold PC / IF-ID register.
- Flush_D, Flush_E  out  1  clear IF-ID / ID-EX register (bubble).
- err  out  1  sticky load-timeout flag.
- state_o  out  2  FSM state (debug).

Behaviour:
- Match rule: source matches destination only if addresses are equal, RegW is set and the vector flag is equal. Scalar address 0 never matches; vector address 0 does.
- Forwarding is combinational and applies in every state. For each operand: MEM match → 10, else WB match → 01, else 00. MEM has priority when both match.
- FSM states, registered: RUN=00, LOAD_WAIT=01, FLUSH=10.
- Reset (rst low, async): state RUN, counters 0, err 0. Stall_F, Stall_D, Flush_D and Flush_E are all 0 while in reset.
- RUN outputs: stalls 0, flushes 0, except for the two cases below.
- RUN + JmpSel_E: assert Flush_D and Flush_E this cycle; go to FLUSH with fcnt=FLUSH_CYC-1. Jump has priority over load-use.
- RUN + load-use: load-use means MemRd_E and a D-stage source (with its Use bit) matches RD_E/VFD_E.
  - Assert Stall_F, Stall_D and Flush_E this cycle.
  - If mem_ready is high this same cycle, stay in RUN (single bubble).
  - Otherwise go to LOAD_WAIT with wcnt=0.
- LOAD_WAIT: assert Stall_F, Stall_D and Flush_E every cycle.
  - On mem_ready, return to RUN next cycle; the stall ends.
  - When wcnt reaches LOAD_TO, set err, return to RUN and drop the stall.
  - Otherwise wcnt increments. The wcnt width is clog2(LOAD_TO+1).
  - JmpSel_E is ignored here (execute holds a bubble).
- FLUSH: assert Flush_D only.
  - Decrement fcnt; go to RUN when fcnt==0, so Flush_D totals FLUSH_CYC+1 cycles including the RUN cycle.
  - If FLUSH_CYC=0, return to RUN directly.
  - A load-use detected in FLUSH is ignored, because D holds a flushed bubble.
- err clears only on reset.
- Reset mid-stall or mid-flush: immediate return to RUN with all control outputs 0.
- state_o mirrors the state register.

Decomposition:
- Shared package hazard_pkg: state enum (RUN, LOAD_WAIT, FLUSH), forwarding-select constants (FWD_RF=00, FWD_WB=01, FWD_MEM=10), REG_W default.
- One sub-module, forward_unit: the purely combinational match/priority logic, instantiated once. It is reused for load-use matching via a function in the package.

Test Plan:
- Reset: hold rst=0 with random inputs → all control outputs 0, state_o=00, Fwd=00. Release and apply no hazards → outputs stay 0.
- Forwarding: RS1_E=2, RD_M=2, RegW_M=1, VF equal → FwdA_E=10. Also RD_W=2, RegW_W=1 → still 10. Clear RegW_M → 01. Set VF_M≠VF_E → no MEM match. Scalar RS=0 with a matching dest → 00.
- Load-use with mem_ready delayed 3 cycles: MemRd_E=1, RD_E=5, RS2_D=5, Use2_D=1 → Stall_F, Stall_D and Flush_E high for 4 cycles total, then low. state_o goes 00→01→00.
- Load timeout: mem_ready held 0 with LOAD_TO=15 → stall lasts 17 cycles (1 RUN + 16 LOAD_WAIT), err=1 afterwards and remains 1.
- Taken jump: JmpSel_E pulse with FLUSH_CYC=2 → Flush_E high 1 cycle, Flush_D high 3 cycles. A simultaneous load-use condition produces no stall.
- Async reset mid-LOAD_WAIT: drop rst between clock edges → outputs go 0 immediately, state_o=00, err=0.
